// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART-ALU datapath: serializer FSM
// states, result byte-count derivation and the default frame sync byte.
package uart_alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_ACK,
    WAIT_DONE,
    NEXT
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Number of whole bytes needed to carry an nb_result-bit value.
  function automatic int num_bytes_f(input int nb_result, input int nb_byte);
    return (nb_result + nb_byte - 1) / nb_byte;
  endfunction

endpackage

// File: rtl/result_byte_serializer.sv
// Captures an ALU result and feeds it LSB byte first to an 8-bit UART transmitter.
// Define RESULT_SERIALIZER_HEADER_EN to prefix each frame with SYNC_BYTE.
module result_byte_serializer
  import uart_alu_pkg::*;
#(
  parameter int                 NB_RESULT = 16,
  parameter int                 NB_BYTE   = 8,
  parameter logic [NB_BYTE-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NB_RESULT-1:0] i_result,
  input  logic                 i_result_valid,
  input  logic                 i_tx_busy,
  input  logic                 i_tx_done,
  output logic                 o_tx_start,
  output logic [NB_BYTE-1:0]   o_tx_data,
  output logic                 o_busy,
  output logic                 o_frame_done,
  output logic                 o_overrun
);

  localparam int NUM_BYTES = num_bytes_f(NB_RESULT, NB_BYTE);
  localparam int SHADOW_W  = NUM_BYTES * NB_BYTE;
`ifdef RESULT_SERIALIZER_HEADER_EN
  localparam int HDR_OFS   = 1;
`else
  localparam int HDR_OFS   = 0;
`endif
  localparam int                FRAME_LEN = NUM_BYTES + HDR_OFS;
  localparam int                IDX_W     = $clog2(FRAME_LEN + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(FRAME_LEN - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      index_q, index_d;
  logic [SHADOW_W-1:0]   shadow_q, shadow_d;
  logic                  tx_start_q, tx_start_d;
  logic [NB_BYTE-1:0]    tx_data_q, tx_data_d;
  logic                  frame_done_q, frame_done_d;
  logic                  overrun_q, overrun_d;
  logic [NB_BYTE-1:0]    cur_byte;

  // Frame slot 0 is the sync byte when the header is enabled; result bytes follow.
  always_comb begin
    cur_byte = SYNC_BYTE;
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (int'(index_q) == b + HDR_OFS) cur_byte = shadow_q[b*NB_BYTE +: NB_BYTE];
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d      = state_q;
    index_d      = index_q;
    shadow_d     = shadow_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    if (i_result_valid && state_q != IDLE) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (i_result_valid) begin
          shadow_d = SHADOW_W'(i_result);
          index_d  = '0;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (!i_tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = cur_byte;
          state_d    = WAIT_ACK;
        end
      end
      // A transmitter may finish before its busy flag is ever seen here.
      WAIT_ACK: begin
        if (i_tx_done) begin
          frame_done_d = (index_q == LAST_IDX);
          state_d      = NEXT;
        end else if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          frame_done_d = (index_q == LAST_IDX);
          state_d      = NEXT;
        end
      end
      NEXT: begin
        if (index_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          index_d = index_q + IDX_W'(1);
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; the shadow
  // register is reset too so a frame never carries stale data after reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      shadow_q     <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      shadow_q     <= shadow_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign o_tx_start   = tx_start_q;
  assign o_tx_data    = tx_data_q;
  assign o_busy       = (state_q != IDLE);
  assign o_frame_done = frame_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_result_byte_serializer.sv
// Self-checking bench for result_byte_serializer with a behavioural UART
// transmitter model; honours RESULT_SERIALIZER_HEADER_EN when defined.
module tb_result_byte_serializer;

  localparam int NUM_BYTES = 2;
`ifdef RESULT_SERIALIZER_HEADER_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_result;
  logic        i_result_valid;
  logic        i_tx_busy;
  logic        i_tx_done;
  logic        o_tx_start;
  logic [7:0]  o_tx_data;
  logic        o_busy;
  logic        o_frame_done;
  logic        o_overrun;

  result_byte_serializer dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_result       (i_result),
    .i_result_valid (i_result_valid),
    .i_tx_busy      (i_tx_busy),
    .i_tx_done      (i_tx_done),
    .o_tx_start     (o_tx_start),
    .o_tx_data      (o_tx_data),
    .o_busy         (o_busy),
    .o_frame_done   (o_frame_done),
    .o_overrun      (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy for tx_len cycles then a done pulse, or an
  // immediate done with busy never raised in fast mode.
  int tx_len    = 10;
  bit fast_tx   = 1'b0;
  bit ext_busy  = 1'b0;
  bit tx_active = 1'b0;
  int tx_cnt    = 0;

  initial begin
    i_tx_busy = 1'b0;
    i_tx_done = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      i_tx_done = 1'b0;
      if (!i_reset) begin
        tx_active = 1'b0;
      end else if (tx_active) begin
        tx_cnt--;
        if (tx_cnt <= 0) begin
          tx_active = 1'b0;
          i_tx_done = 1'b1;
        end
      end else if (o_tx_start) begin
        if (fast_tx) i_tx_done = 1'b1;
        else begin
          tx_active = 1'b1;
          tx_cnt    = tx_len;
        end
      end
      i_tx_busy = tx_active | ext_busy;
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int   n_starts = 0, n_done = 0, stab_err = 0, busy_err = 0, frames_sent = 0;
  bit   in_byte = 1'b0;
  logic [7:0] held = '0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (!i_reset) begin
        in_byte = 1'b0;
      end else begin
        if (o_tx_start) begin
          got_q.push_back(o_tx_data);
          n_starts++;
          held    = o_tx_data;
          in_byte = 1'b1;
        end else if (in_byte && o_tx_data !== held) begin
          stab_err++;
        end
        if (i_tx_done) in_byte = 1'b0;
        if (o_frame_done) begin
          n_done++;
          if (o_busy !== 1'b1) busy_err++;
        end
      end
    end
  end

  // Reference: optional sync byte, then the result bytes LSB first.
  function automatic void build_expected(input logic [15:0] r);
    logic [15:0] t;
    exp_q.delete();
    if (HDR) exp_q.push_back(8'hA5);
    for (int k = 0; k < NUM_BYTES; k++) begin
      t = r >> (8 * k);
      exp_q.push_back(t[7:0]);
    end
  endfunction

  task automatic send(input logic [15:0] r);
    @(posedge i_clk);
    #1;
    i_result       = r;
    i_result_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_result_valid = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int d0 = n_done;
    int k  = 0;
    while (n_done == d0 && k < 400) begin
      @(posedge i_clk);
      k++;
    end
    check({name, "_frame_done_seen"}, 32'(n_done != d0), 32'd1);
    frames_sent++;
  endtask

  task automatic wait_starts(input string name, input int n);
    int k = 0;
    while (n_starts < n && k < 400) begin
      @(posedge i_clk);
      k++;
    end
    check({name, "_start_seen"}, 32'(n_starts >= n), 32'd1);
  endtask

  task automatic compare_frame(input string name);
    check({name, "_nbytes"}, got_q.size(), exp_q.size());
    check({name, "_nstarts"}, n_starts, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i),
            (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hxxxx_xxxx, {24'd0, exp_q[i]});
    end
  endtask

  task automatic run_frame(input string name, input logic [15:0] r, input int len, input bit fast);
    tx_len  = len;
    fast_tx = fast;
    got_q.delete();
    n_starts = 0;
    send(r);
    wait_frame(name);
    compare_frame(name);
    @(posedge i_clk);
    #1;
    check({name, "_idle_after"}, o_busy, 1'b0);
  endtask

  typedef struct {
    logic [15:0] result;
    int          len;
    bit          fast;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r, r2;

    vecs[0] = '{16'hBEEF, 20, 1'b0, 8'hEF, 8'hBE};
    vecs[1] = '{16'h0000,  1, 1'b1, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF,  3, 1'b0, 8'hFF, 8'hFF};
    vecs[3] = '{16'h0102,  5, 1'b0, 8'h02, 8'h01};

    i_reset        = 1'b0;
    i_result       = '0;
    i_result_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_outputs", {o_busy, o_tx_start, o_tx_data, o_frame_done, o_overrun}, 12'd0);
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);

    // Table-driven frames: constant expected bytes, sync byte added in header builds.
    for (int v = 0; v < 4; v++) begin
      exp_q.delete();
      if (HDR) exp_q.push_back(8'hA5);
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      run_frame($sformatf("vec%0d", v), vecs[v].result, vecs[v].len, vecs[v].fast);
    end

    // New valid accepted the cycle right after o_frame_done.
    tx_len = 4; fast_tx = 1'b0;
    build_expected(16'h7E81);
    got_q.delete(); n_starts = 0;
    send(16'h7E81);
    wait_frame("b2b_a");
    compare_frame("b2b_a");
    build_expected(16'h3CC3);
    got_q.delete(); n_starts = 0;
    #1;
    i_result = 16'h3CC3; i_result_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_result_valid = 1'b0;
    wait_frame("b2b_b");
    compare_frame("b2b_b");
    check("b2b_no_overrun", o_overrun, 1'b0);

    // Randomised frames checked against the reference model.
    for (int n = 0; n < 12; n++) begin
      r = 16'($urandom);
      build_expected(r);
      run_frame($sformatf("rand%0d", n), r, int'($urandom_range(1, 12)), ($urandom_range(0, 3) == 0));
    end
    check("rand_no_overrun", o_overrun, 1'b0);

    // Transmitter already busy: nothing may start until it frees up.
    tx_len = 6; fast_tx = 1'b0;
    ext_busy = 1'b1;
    repeat (2) @(posedge i_clk);
    build_expected(16'h1234);
    got_q.delete(); n_starts = 0;
    send(16'h1234);
    repeat (50) @(posedge i_clk);
    check("busy_hold_no_start", n_starts, 0);
    check("busy_hold_obusy", o_busy, 1'b1);
    ext_busy = 1'b0;
    wait_frame("busy");
    compare_frame("busy");

    // Overrun: second valid during the first byte is dropped and sticks.
    tx_len = 20;
    build_expected(16'hA0A0);
    got_q.delete(); n_starts = 0;
    send(16'hA0A0);
    wait_starts("ovr", 1);
    send(16'h5555);
    wait_frame("ovr");
    compare_frame("ovr");
    check("ovr_flag", o_overrun, 1'b1);
    repeat (5) @(posedge i_clk);
    #1;
    check("ovr_sticky", o_overrun, 1'b1);

    // Asynchronous reset during the second byte aborts the frame at once.
    tx_len = 20;
    got_q.delete(); n_starts = 0;
    send(16'hC3C3);
    wait_starts("rst", 2);
    @(negedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    check("rst_async_outputs", {o_busy, o_tx_start, o_tx_data, o_frame_done, o_overrun}, 12'd0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    repeat (2) @(posedge i_clk);
    build_expected(16'h00FF);
    run_frame("post_rst", 16'h00FF, 5, 1'b0);

    check("frame_done_total", n_done, frames_sent);
    check("data_stable_while_sending", stab_err, 0);
    check("busy_high_at_frame_done", busy_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
